// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and the
// read-response owner encoding.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 18;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU load/store path and
// the external loader/debug port; read data returns one cycle after the grant.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int LOCK_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    logic       last_ext_q, last_ext_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    owner_e     rsp_owner_q, rsp_owner_d;

    logic       lock_active;
    logic       cpu_win;
    logic       ext_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_ext_q  <= 1'b1;
            lock_cnt_q  <= 8'd0;
            rsp_owner_q <= OWN_NONE;
        end else begin
            last_ext_q  <= last_ext_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    // Winner select; grants are forced low while reset is held.
    always_comb begin
        lock_active = last_ext_q && ext_lock && ext_req && (lock_cnt_q < LOCK_MAX_C);
        cpu_win     = 1'b0;
        ext_win     = 1'b0;
        if (reset) begin
            if (cpu_req && ext_req) begin
                if (lock_active) begin
                    ext_win = 1'b1;
                end else if (last_ext_q) begin
                    cpu_win = 1'b1;
                end else begin
                    ext_win = 1'b1;
                end
            end else begin
                cpu_win = cpu_req;
                ext_win = ext_req;
            end
        end
    end

    always_comb begin
        last_ext_d = last_ext_q;
        if (cpu_win) begin
            last_ext_d = 1'b0;
        end else if (ext_win) begin
            last_ext_d = 1'b1;
        end

        lock_cnt_d = lock_cnt_q;
        if (cpu_win || !ext_lock) begin
            lock_cnt_d = 8'd0;
        end else if (ext_win) begin
            lock_cnt_d = (lock_cnt_q >= LOCK_MAX_C) ? LOCK_MAX_C : lock_cnt_q + 8'd1;
        end

        rsp_owner_d = OWN_NONE;
        if (cpu_win && !cpu_we) begin
            rsp_owner_d = OWN_CPU;
        end else if (ext_win && !ext_we) begin
            rsp_owner_d = OWN_EXT;
        end
    end

    always_comb begin
        cpu_gnt   = cpu_win;
        ext_gnt   = ext_win;
        cpu_stall = cpu_req & ~cpu_win;

        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_win) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
        mem_we = (cpu_win & cpu_we) | (ext_win & ext_we);
        mem_re = (cpu_win & ~cpu_we) | (ext_win & ~ext_we);

        cpu_rvalid = (rsp_owner_q == OWN_CPU);
        ext_rvalid = (rsp_owner_q == OWN_EXT);
        cpu_rdata  = mem_rdata;
        ext_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read memory model.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, mem_re;

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    int vectors = 0;
    int errors  = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_lock   (ext_lock),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem_q[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_q[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic exp_cpu;
        logic prev_cpu;

        for (int a = 0; a < (1 << AW); a++) mem_q[a] = '0;
        mem_rdata = '0;
        mem_q[5] = 18'h2A5A;

        // Requests during reset must not be granted
        idle_inputs();
        reset   = 1'b0;
        cpu_req = 1'b1;
        ext_req = 1'b1;
        ext_we  = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_ext_gnt", 32'(ext_gnt), 32'd0);
        chk("rst_mem_we",  32'(mem_we),  32'd0);
        chk("rst_mem_re",  32'(mem_re),  32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

        // Lone CPU read of address 5
        idle_inputs();
        @(negedge clk) reset = 1'b1;
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 12'h005;
        #1;
        chk("lone_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("lone_mem_re", 32'(mem_re), 32'd1);
        chk("lone_mem_addr", 32'(mem_addr), 32'h005);
        chk("lone_cpu_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        cpu_req = 1'b0; cpu_addr = '0;
        #1;
        chk("lone_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("lone_cpu_rdata", 32'(cpu_rdata), 32'h2A5A);
        chk("lone_ext_rvalid", 32'(ext_rvalid), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);
        chk("idle_mem_re", 32'(mem_re), 32'd0);
        next_cycle();

        // Unlocked contention alternates, CPU first after reset
        do_reset();
        cpu_req = 1'b1; cpu_addr = 12'h005;
        ext_req = 1'b1; ext_addr = 12'h005;
        prev_cpu = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_cpu = (i % 2 == 0);
            chk("alt_cpu_gnt", 32'(cpu_gnt), 32'(exp_cpu));
            chk("alt_ext_gnt", 32'(ext_gnt), 32'(!exp_cpu));
            chk("alt_cpu_stall", 32'(cpu_stall), 32'(!exp_cpu));
            if (i > 0) begin
                chk("alt_cpu_rvalid", 32'(cpu_rvalid), 32'(prev_cpu));
                chk("alt_ext_rvalid", 32'(ext_rvalid), 32'(!prev_cpu));
            end
            prev_cpu = exp_cpu;
            next_cycle();
        end

        // Locked EXT write burst against a waiting CPU: 15 EXT, 1 CPU, repeat
        do_reset();
        cpu_req = 1'b1; cpu_addr = 12'h000;
        ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1;
        ext_addr = 12'h100; ext_wdata = 18'h1234;
        for (int i = 0; i < 32; i++) begin
            #1;
            exp_cpu = (i == 15) || (i == 31);
            chk("lock_cpu_gnt", 32'(cpu_gnt), 32'(exp_cpu));
            chk("lock_ext_gnt", 32'(ext_gnt), 32'(!exp_cpu));
            chk("lock_mem_we", 32'(mem_we), 32'(!exp_cpu));
            next_cycle();
        end

        // Locked EXT alone for 300 cycles, then the CPU wins immediately
        do_reset();
        ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1;
        ext_addr = 12'h200; ext_wdata = 18'h0BEEF;
        for (int i = 0; i < 300; i++) begin
            #1;
            chk("sat_ext_gnt", 32'(ext_gnt), 32'd1);
            next_cycle();
        end
        cpu_req = 1'b1; cpu_addr = 12'h005;
        #1;
        chk("sat_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("sat_ext_gnt_yield", 32'(ext_gnt), 32'd0);
        next_cycle();
        #1;
        chk("sat_after_ext_gnt", 32'(ext_gnt), 32'd1);
        chk("sat_after_cpu_stall", 32'(cpu_stall), 32'd1);
        next_cycle();

        // EXT writes top address, CPU reads it back the next cycle
        do_reset();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'hFFF; ext_wdata = 18'h3FFFF;
        #1;
        chk("raw_ext_gnt", 32'(ext_gnt), 32'd1);
        chk("raw_mem_we", 32'(mem_we), 32'd1);
        chk("raw_mem_addr_w", 32'(mem_addr), 32'hFFF);
        chk("raw_mem_wdata", 32'(mem_wdata), 32'h3FFFF);
        next_cycle();
        idle_inputs();
        cpu_req = 1'b1; cpu_addr = 12'hFFF;
        #1;
        chk("raw_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("raw_mem_addr_r", 32'(mem_addr), 32'hFFF);
        next_cycle();
        cpu_req = 1'b0;
        #1;
        chk("raw_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("raw_cpu_rdata", 32'(cpu_rdata), 32'h3FFFF);
        next_cycle();

        // Reset right after a CPU read grant drops the response
        do_reset();
        cpu_req = 1'b1; cpu_addr = 12'h005;
        #1;
        chk("rstmid_cpu_gnt", 32'(cpu_gnt), 32'd1);
        next_cycle();
        reset = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rstmid_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        next_cycle();
        #1;
        chk("rstmid_cpu_rvalid_hold", 32'(cpu_rvalid), 32'd0);
        reset = 1'b1;
        cpu_req = 1'b1; ext_req = 1'b1; ext_addr = 12'h005;
        #1;
        chk("rstmid_tie_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rstmid_tie_ext_gnt", 32'(ext_gnt), 32'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
